serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/sub_bit_cell.sv | 13 +
 rtl/serial_subtractor.sv | 117 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_bit_cell.sv
// Combinational 1-bit full subtractor: d = a - b - brw, with borrow out.
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic brw,
  output logic d,
  output logic brw_next
);

  assign d        = a ^ b ^ brw;
  assign brw_next = (~a & b) | (~(a ^ b) & brw);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, one bit per cycle LSB first, with done pulse.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int FULL_SUB = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             brw;
  logic             d_bit, brw_next;
  logic             load, last;

  assign load = start && (state != BUSY);
  assign last = (cnt == CW'(WIDTH - 1));

  sub_bit_cell u_cell (
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .brw      (brw),
    .d        (d_bit),
    .brw_next (brw_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands shift right so the bit cell always sees bit 0; results enter at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      brw  <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= (FULL_SUB != 0) ? bin : 1'b0;
      cnt  <= '0;
    end else if (state == BUSY) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      brw  <= brw_next;
      res  <= {d_bit, res[WIDTH-1:1]};
      if (last) begin
        diff <= {d_bit, res[WIDTH-1:1]};
        bout <= brw_next;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;

  // The final bit processed is the difference MSB, so overflow is decided on the last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if ((state == BUSY) && last) begin
      ovf <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end
`endif

endmodule
